// File: rtl/demux1x8_buf.sv
// Registered 1-to-8 demultiplexer with one buffer slot per destination.
// Define DEMUX_BCAST_EN to add the in_bcast port, which writes one beat into all eight slots.
module demux1x8_buf #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_sel,
   input  logic [WIDTH-1:0]   in_data,
`ifdef DEMUX_BCAST_EN
   input  logic               in_bcast,
`endif
   output logic [7:0]         out_valid,
   input  logic [7:0]         out_ready,
   output logic [8*WIDTH-1:0] out_data,
   output logic               busy
);

   logic [7:0] can_acc;
   logic [7:0] wr_en;
   logic       bcast;

`ifdef DEMUX_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   // A full slot can still take a beat in the same cycle that its destination drains it.
   assign can_acc = ~out_valid | out_ready;

   // NOTE: each signal gets a default at the top of the block, so no latch is inferred.
   always_comb begin
      in_ready = can_acc[in_sel];
      wr_en    = 8'h00;
      if (bcast && in_valid) begin
         in_ready = &can_acc;
      end
      if (in_valid && in_ready) begin
         wr_en = bcast ? 8'hFF : (8'h01 << in_sel);
      end
   end

   // NOTE: the payload slots are reset as well, because out_data must read as zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 8'h00;
         out_data  <= '0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (wr_en[k]) begin
               out_valid[k]                <= 1'b1;
               out_data[k*WIDTH +: WIDTH]  <= in_data;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

   assign busy = |out_valid;

endmodule

// File: tb/tb_demux1x8_buf.sv
// Directed self-checking bench for demux1x8_buf: reset, unicast stalls and drains, lane independence.
// Also checks back-to-back sweeps, reset dominance and, when DEMUX_BCAST_EN is defined, broadcast.
module tb_demux1x8_buf;

   localparam int WIDTH = 32;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         in_sel;
   logic [WIDTH-1:0]   in_data;
`ifdef DEMUX_BCAST_EN
   logic               in_bcast;
`endif
   logic [7:0]         out_valid;
   logic [7:0]         out_ready;
   logic [8*WIDTH-1:0] out_data;
   logic               busy;

   int checks = 0;
   int errors = 0;

   demux1x8_buf #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
`ifdef DEMUX_BCAST_EN
      .in_bcast  (in_bcast),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] lane(input int k);
      return out_data[k*WIDTH +: WIDTH];
   endfunction

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_sel    = 3'd3;
      in_data   = 32'hFFFF_FFFF;
      out_ready = 8'h00;
`ifdef DEMUX_BCAST_EN
      in_bcast  = 1'b0;
`endif

      // Reset held for two edges with a beat presented: the beat is dropped.
      tick();
      tick();
      chk("rst_valid", out_valid, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", out_data, '0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("post_rst_valid", out_valid, 8'h00);

      // Single beat to lane 5, then a second beat stalls behind it.
      in_valid = 1'b1;
      in_sel   = 3'd5;
      in_data  = 32'hA5A5_0005;
      #1;
      chk("t2_ready_empty", in_ready, 1'b1);
      tick();
      chk("t2_valid", out_valid, 8'h20);
      chk("t2_lane5", lane(5), 32'hA5A5_0005);
      chk("t2_busy", busy, 1'b1);
      in_data = 32'hA5A5_0006;
      #1;
      chk("t2_ready_full", in_ready, 1'b0);
      tick();
      chk("t2_stall_valid", out_valid, 8'h20);
      chk("t2_stall_lane5", lane(5), 32'hA5A5_0005);

      // Drain and write to the same lane in one cycle.
      out_ready = 8'h20;
      in_data   = 32'h0000_1234;
      #1;
      chk("t3_ready", in_ready, 1'b1);
      tick();
      chk("t3_valid", out_valid, 8'h20);
      chk("t3_lane5", lane(5), 32'h0000_1234);
      in_valid = 1'b0;
      tick();
      chk("t3_drained", out_valid, 8'h00);
      chk("t3_data_held", lane(5), 32'h0000_1234);
      chk("t3_busy", busy, 1'b0);

      // A stalled lane 2 does not block a beat to lane 3.
      out_ready = 8'h00;
      in_valid  = 1'b1;
      in_sel    = 3'd2;
      in_data   = 32'h2222_2222;
      tick();
      chk("t4_lane2_valid", out_valid, 8'h04);
      in_sel  = 3'd3;
      in_data = 32'h3333_3333;
      #1;
      chk("t4_ready_sel3", in_ready, 1'b1);
      tick();
      chk("t4_valid", out_valid, 8'h0C);
      chk("t4_lane2", lane(2), 32'h2222_2222);
      chk("t4_lane3", lane(3), 32'h3333_3333);
      in_valid  = 1'b0;
      out_ready = 8'hFF;
      tick();
      chk("t4_drain_all", out_valid, 8'h00);

      // Back-to-back sweep over all lanes with every destination ready.
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_sel  = 3'(i);
         in_data = 32'hC0DE_0000 + 32'(i);
         #1;
         chk($sformatf("t5_ready_%0d", i), in_ready, 1'b1);
         tick();
         chk($sformatf("t5_valid_%0d", i), out_valid, 8'h01 << i);
         chk($sformatf("t5_lane_%0d", i), lane(i), 32'hC0DE_0000 + 32'(i));
      end
      in_valid = 1'b0;
      tick();
      chk("t5_end_valid", out_valid, 8'h00);
      chk("t5_lane0_held", lane(0), 32'hC0DE_0000);

      // Reset wins over a simultaneous accept.
      out_ready = 8'h00;
      in_valid  = 1'b1;
      in_sel    = 3'd1;
      in_data   = 32'h1111_1111;
      tick();
      chk("rst2_pre_valid", out_valid, 8'h02);
      rst     = 1'b1;
      in_sel  = 3'd4;
      in_data = 32'h4444_4444;
      tick();
      chk("rst2_valid", out_valid, 8'h00);
      chk("rst2_data", out_data, '0);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();

`ifdef DEMUX_BCAST_EN
      // Broadcast waits for every slot, then loads all eight.
      in_valid = 1'b1;
      in_sel   = 3'd6;
      in_data  = 32'h6666_6666;
      tick();
      chk("t6_lane6_full", out_valid, 8'h40);
      in_bcast = 1'b1;
      in_sel   = 3'd0;
      in_data  = 32'hDEAD_BEEF;
      #1;
      chk("t6_ready_blocked", in_ready, 1'b0);
      tick();
      chk("t6_stall_valid", out_valid, 8'h40);
      out_ready = 8'h40;
      #1;
      chk("t6_ready_release", in_ready, 1'b1);
      tick();
      chk("t6_valid_all", out_valid, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t6_lane_%0d", i), lane(i), 32'hDEAD_BEEF);
      end
      in_bcast  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 8'h00;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
